// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port clearable block RAM.
package bram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } clear_state_e;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/bram_clear_ctrl.sv
// Clear engine: sweeps every address once after reset or on request, then holds ready.
module bram_clear_ctrl
  import bram_pkg::*;
#(
  parameter int P_ADDRESS_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_req,
  output logic [P_ADDRESS_WIDTH-1:0] sweep_addr,
  output logic                       sweep_we,
  output logic                       ready
);

  clear_state_e               state;
  logic [P_ADDRESS_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clear_req) begin
            cnt <= '0;
          end else if (&cnt) begin
            state <= S_READY;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READY: begin
          if (clear_req) begin
            state <= S_CLEAR;
            ready <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_CLEAR;
          ready <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign sweep_addr = cnt;
  assign sweep_we   = ~ready;

endmodule

// File: rtl/bram_dp_clear.sv
// Dual-port byte-enabled block RAM with a built-in clear sweep.
// Optional BRAM_COLLISION_FLAG_EN adds O_COLLISION for overlapping same-address writes.
module bram_dp_clear
  import bram_pkg::*;
#(
  parameter int                      P_DATA_WIDTH    = 16,
  parameter int                      P_ADDRESS_WIDTH = 10,
  parameter int                      P_READ_MODE     = READ_FIRST,
  parameter logic [P_DATA_WIDTH-1:0] P_CLEAR_VALUE   = '0
) (
  input  logic                                I_CLK,
  input  logic                                I_RESET,
  input  logic                                I_CLEAR,
  input  logic [P_DATA_WIDTH-1:0]             I_DATA_A,
  input  logic [P_DATA_WIDTH-1:0]             I_DATA_B,
  input  logic [P_ADDRESS_WIDTH-1:0]          I_ADDRESS_A,
  input  logic [P_ADDRESS_WIDTH-1:0]          I_ADDRESS_B,
  input  logic                                I_WRITE_ENABLE_A,
  input  logic                                I_WRITE_ENABLE_B,
  input  logic [byte_lanes(P_DATA_WIDTH)-1:0] I_BYTE_ENABLE_A,
  input  logic [byte_lanes(P_DATA_WIDTH)-1:0] I_BYTE_ENABLE_B,
  output logic [P_DATA_WIDTH-1:0]             O_DATA_A,
  output logic [P_DATA_WIDTH-1:0]             O_DATA_B,
  output logic                                O_READY
`ifdef BRAM_COLLISION_FLAG_EN
  ,
  output logic                                O_COLLISION
`endif
);

  localparam int NB    = byte_lanes(P_DATA_WIDTH);
  localparam int DEPTH = 1 << P_ADDRESS_WIDTH;

  logic [P_ADDRESS_WIDTH-1:0] sweep_addr;
  logic                       sweep_we;
  logic                       ready;

  bram_clear_ctrl #(
    .P_ADDRESS_WIDTH(P_ADDRESS_WIDTH)
  ) u_ctrl (
    .clk       (I_CLK),
    .rst       (I_RESET),
    .clear_req (I_CLEAR),
    .sweep_addr(sweep_addr),
    .sweep_we  (sweep_we),
    .ready     (ready)
  );

  assign O_READY = ready;

  function automatic logic [P_DATA_WIDTH-1:0] merge(input logic [P_DATA_WIDTH-1:0] old_w,
                                                    input logic [P_DATA_WIDTH-1:0] new_w,
                                                    input logic [NB-1:0]           be);
    logic [P_DATA_WIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++)
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];

  logic port_en, wr_a, wr_b, same_addr;
  assign port_en   = ready & ~I_RESET;
  assign wr_a      = port_en & I_WRITE_ENABLE_A;
  assign wr_b      = port_en & I_WRITE_ENABLE_B;
  assign same_addr = (I_ADDRESS_A == I_ADDRESS_B);

  // B lanes first so A's lanes overwrite them when both hit the same word.
  always_ff @(posedge I_CLK) begin
    if (sweep_we) begin
      mem[sweep_addr] <= P_CLEAR_VALUE;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wr_b && I_BYTE_ENABLE_B[k]) mem[I_ADDRESS_B][8*k +: 8] <= I_DATA_B[8*k +: 8];
        if (wr_a && I_BYTE_ENABLE_A[k]) mem[I_ADDRESS_A][8*k +: 8] <= I_DATA_A[8*k +: 8];
      end
    end
  end

  logic [P_DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;
  logic [NB-1:0]           be_a_eff, be_b_eff, be_a_x, be_b_x;

  // Final stored word per port, including the other port's lanes on a shared address.
  always_comb begin
    old_a    = mem[I_ADDRESS_A];
    old_b    = mem[I_ADDRESS_B];
    be_a_eff = wr_a ? I_BYTE_ENABLE_A : '0;
    be_b_eff = wr_b ? I_BYTE_ENABLE_B : '0;
    be_a_x   = same_addr ? be_a_eff : '0;
    be_b_x   = same_addr ? be_b_eff : '0;
    new_a    = merge(merge(old_a, I_DATA_B, be_b_x), I_DATA_A, be_a_eff);
    new_b    = merge(merge(old_b, I_DATA_B, be_b_eff), I_DATA_A, be_a_x);
    rd_a     = (P_READ_MODE == WRITE_FIRST && wr_a) ? new_a : old_a;
    rd_b     = (P_READ_MODE == WRITE_FIRST && wr_b) ? new_b : old_b;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET || !ready || I_CLEAR) begin
      O_DATA_A <= '0;
      O_DATA_B <= '0;
    end else begin
      O_DATA_A <= rd_a;
      O_DATA_B <= rd_b;
    end
  end

`ifdef BRAM_COLLISION_FLAG_EN
  always_ff @(posedge I_CLK) begin
    if (I_RESET) O_COLLISION <= 1'b0;
    else         O_COLLISION <= wr_a & wr_b & same_addr & (|(I_BYTE_ENABLE_A & I_BYTE_ENABLE_B));
  end
`endif

endmodule

// File: doc/bram_dp_clear.md
# bram_dp_clear

Parametrised dual-port block RAM for the CompactRISC16 datapath and memory-mapped I/O region. Two independent synchronous read/write ports with per-byte write enables and a selectable read-during-write mode. A built-in clear engine sweeps every word to a constant after reset or on request, and gates both ports while it runs. It is the drop-in successor to the existing dual-port `bram` for instruction/data memory and frame buffers.

## Interface
- `P_DATA_WIDTH`, 16, word width in bits; must be a multiple of 8.
- `P_ADDRESS_WIDTH`, 10, address bits; depth = 2^P_ADDRESS_WIDTH.
- `P_READ_MODE`, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
- `P_CLEAR_VALUE`, 0, word written to every address by the clear engine.
- `I_CLK`  in  1  sole clock; all logic on rising edge.
- `I_RESET`  in  1  synchronous, active-high reset.
- `I_CLEAR`  in  1  single-cycle request to re-clear the whole array.
- `I_DATA_A`, `I_DATA_B`  in  P_DATA_WIDTH  write data per port.
- `I_ADDRESS_A`, `I_ADDRESS_B`  in  P_ADDRESS_WIDTH  address per port.
- `I_WRITE_ENABLE_A`, `I_WRITE_ENABLE_B`  in  1  write strobe per port.
- `I_BYTE_ENABLE_A`, `I_BYTE_ENABLE_B`  in  P_DATA_WIDTH/8  byte lanes written when the strobe is high; bit k covers bits 8k+7..8k.
- `O_DATA_A`, `O_DATA_B`  out  P_DATA_WIDTH  registered read data.
- `O_READY`  out  1  high when ports are serviced; low while clearing.
- `O_COLLISION`  out  1  present only with `BRAM_COLLISION_FLAG_EN`; see Configuration.

## Operation
- Clear FSM states: `S_CLEAR`, `S_READY`.
- `I_RESET` puts the FSM in `S_CLEAR` with the sweep counter at 0, regardless of the current state.
- `S_CLEAR`: each cycle writes `P_CLEAR_VALUE` to the address held in the counter, then increments the counter. After address 2^P_ADDRESS_WIDTH−1 is written, the FSM moves to `S_READY`.
- `I_CLEAR` in `S_READY`: the FSM enters `S_CLEAR` with the counter at 0.
- `I_CLEAR` during `S_CLEAR`: the counter restarts at 0.
- In `S_CLEAR`, port writes are ignored and both `O_DATA` outputs are 0.
- `S_READY`, each port independently:
  - Write: when the strobe is high, enabled bytes at the address are updated at the edge.
  - Read: always performed; data appears on `O_DATA_x` after the edge.
  - Same-port read-during-write returns old data (P_READ_MODE 0) or the merged new word (P_READ_MODE 1).
- Cross-port read of an address the other port writes in the same cycle always returns the old word.
- Both ports write the same address in one cycle:
  - Bytes enabled on A take A's data.
  - Bytes enabled only on B take B's data.
- Addresses wrap naturally; there is no out-of-range case.

## Timing
- Reset values: `O_DATA_A` = `O_DATA_B` = 0, `O_READY` = 0, `O_COLLISION` = 0.
- Clear takes exactly 2^P_ADDRESS_WIDTH cycles.
- `O_READY` rises on the edge after the last sweep write.
- Read latency is 1 cycle: the address presented before edge N gives data valid after edge N.
- A write at edge N is visible to either port's read at edge N+1.
- A request issued while `O_READY` is low is dropped, not queued. Masters must qualify requests with `O_READY`.

## Configuration
- `BRAM_COLLISION_FLAG_EN` defined:
  - `O_COLLISION` exists.
  - It is registered high for one cycle after any edge in `S_READY` where both write strobes are high, the addresses are equal, and the byte enables overlap.
- Undefined: the port and its logic are absent. Collision resolution (A wins) is unchanged.

## Structure
- `bram_pkg`: clear-FSM state enum, `READ_FIRST`/`WRITE_FIRST` constants, byte-lane count function.
- Sub-module `bram_clear_ctrl`: FSM plus sweep counter. It outputs the sweep address, sweep write enable and `O_READY`.
- The top level owns the array, port muxing and the byte-merge logic.

## Test plan
1. Reset: hold `I_RESET` 1 cycle with AW=4. Expect `O_READY` low for exactly 16 cycles, then high. Reading all 16 addresses returns 0 (P_CLEAR_VALUE=0).
2. Byte enables: A writes 16'hABCD to address 3 with BE=2'b11, then 16'h1200 with BE=2'b10. Port B reads 16'h12CD.
3. Read mode: A holds address 5 (value 16'h0007) and writes 16'h0009. `O_DATA_A` the next cycle is 16'h0007 with P_READ_MODE=0 and 16'h0009 with P_READ_MODE=1. B reading 5 in the same cycle gets 16'h0007.
4. Collision:
   - A writes 16'h1111 (BE 01) and B writes 16'h2222 (BE 11) to address 7 in the same cycle.
   - Readback is 16'h2211.
   - With `BRAM_COLLISION_FLAG_EN`, `O_COLLISION` pulses for 1 cycle.
5. Mid-clear events:
   - Pulse `I_CLEAR` after writing 16'hFFFF everywhere. Pulse it again 5 cycles into the sweep; `O_READY` stays low for 16 further cycles.
   - A port-A write during the sweep is lost, and all words read back 0.
   - `I_RESET` mid-sweep also restarts the full 16-cycle sweep.
